// File: rtl/core_pkg.sv
// Shared types and constants for the fetch-stage PC logic.
// Optional misaligned-target handling is enabled with PC_REDIRECT_ALIGN_CHECK_EN.
package core_pkg;

  localparam int PC_WIDTH = 32;

  typedef logic [PC_WIDTH-1:0] pc_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1
  } redir_state_e;

  localparam pc_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int  PC_INC           = 4;

endpackage

// File: rtl/redirect_arbiter.sv
// Combinational age-priority select among redirect requests: JR > branch > jump.
// EX-class requests (JR/branch) flush two stages; the ID-class jump flushes one.
module redirect_arbiter
  import core_pkg::*;
#(
  parameter int PC_W = PC_WIDTH
) (
  input  logic            jr_control,
  input  logic [PC_W-1:0] jr_target,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  output logic            sel_valid,
  output logic            sel_ex,
  output logic [PC_W-1:0] sel_target
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    sel_valid  = 1'b0;
    sel_ex     = 1'b0;
    sel_target = jump_target;
    if (jr_control) begin
      sel_valid  = 1'b1;
      sel_ex     = 1'b1;
      sel_target = jr_target;
    end else if (branch_taken) begin
      sel_valid  = 1'b1;
      sel_ex     = 1'b1;
      sel_target = branch_target;
    end else if (jump) begin
      sel_valid  = 1'b1;
      sel_target = jump_target;
    end
  end

endmodule

// File: rtl/pc_redirect.sv
// Fetch PC owner: advances by 4, applies prioritised redirects, holds a redirect across stalls.
// Define PC_REDIRECT_ALIGN_CHECK_EN to force targets word-aligned and pulse misalign.
module pc_redirect
  import core_pkg::*;
#(
  parameter int          RESET_PC = RESET_PC_DEFAULT,
  parameter int          PC_W     = PC_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            jr_control,
  input  logic [PC_W-1:0] jr_target,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            redirect,
  output logic            misalign
);

  redir_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_target_q, pend_target_d;
  logic            pend_ex_q, pend_ex_d;

  logic            sel_valid, sel_ex;
  logic [PC_W-1:0] sel_target;
  logic            apply, apply_ex;
  logic [PC_W-1:0] apply_target, load_target;

  redirect_arbiter #(.PC_W(PC_W)) u_arb (
    .jr_control    (jr_control),
    .jr_target     (jr_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .sel_valid     (sel_valid),
    .sel_ex        (sel_ex),
    .sel_target    (sel_target)
  );

  // In PEND the live request inputs belong to the stalled producer, so only the captured one counts.
  always_comb begin
    apply_target = sel_target;
    apply_ex     = sel_ex;
    apply        = sel_valid && !stall;
    if (state_q == PEND) begin
      apply_target = pend_target_q;
      apply_ex     = pend_ex_q;
      apply        = !stall;
    end
  end

`ifdef PC_REDIRECT_ALIGN_CHECK_EN
  logic misalign_q;

  assign load_target = {apply_target[PC_W-1:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= apply && (apply_target[1:0] != 2'b00);
  end

  assign misalign = misalign_q;
`else
  assign load_target = apply_target;
  assign misalign    = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    pend_ex_d     = pend_ex_q;
    if (apply) begin
      pc_d    = load_target;
      state_d = RUN;
    end else if (stall) begin
      if (state_q == RUN && sel_valid) begin
        state_d       = PEND;
        pend_target_d = sel_target;
        pend_ex_d     = sel_ex;
      end
    end else begin
      pc_d = pc_q + PC_W'(PC_INC);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= PC_W'(RESET_PC);
      pend_target_q <= '0;
      pend_ex_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      pend_ex_q     <= pend_ex_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + PC_W'(PC_INC);
  assign redirect    = apply;
  assign flush_if_id = apply;
  assign flush_id_ex = apply && apply_ex;

endmodule
